// File: rtl/clk_div_n.sv
// Programmable divide-by-N clock generator with a start-of-period tick and a stop/start control
// that takes effect only on period boundaries, so out_clk never has a shortened pulse.
module clk_div_n #(
    parameter int CNT_W = 8
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             enable,
    output logic             out_clk,
    output logic             out_tick,
    output logic             running
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] ratio_act_r;
    logic [CNT_W-1:0] ratio_clamped_s;
    logic [CNT_W-1:0] high_len_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             period_last_s;

    // Clamp the requested ratio and derive the per-period compare values
    always_comb begin
        ratio_clamped_s = div_ratio;
        if (div_ratio < CNT_W'(2)) begin
            ratio_clamped_s = CNT_W'(2);
        end else begin
            ratio_clamped_s = div_ratio;
        end
        high_len_s    = ratio_act_r >> 1;
        cnt_inc_s     = cnt_r + CNT_W'(1);
        period_last_s = (cnt_r == (ratio_act_r - CNT_W'(1)));
    end

    // Period FSM; the ratio and enable are only sampled when a period begins or ends
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            ratio_act_r <= CNT_W'(2);
            out_clk     <= 1'b0;
            out_tick    <= 1'b0;
            running     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        state_r     <= RUN;
                        cnt_r       <= '0;
                        ratio_act_r <= ratio_clamped_s;
                        out_clk     <= 1'b1;
                        out_tick    <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        out_clk     <= 1'b0;
                        out_tick    <= 1'b0;
                        running     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!period_last_s) begin
                        cnt_r    <= cnt_inc_s;
                        out_clk  <= (cnt_inc_s < high_len_s);
                        out_tick <= 1'b0;
                    end else if (enable) begin
                        // Back-to-back restart keeps the output gapless
                        cnt_r       <= '0;
                        ratio_act_r <= ratio_clamped_s;
                        out_clk     <= 1'b1;
                        out_tick    <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        cnt_r    <= '0;
                        out_clk  <= 1'b0;
                        out_tick <= 1'b0;
                        running  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= '0;
                    out_clk  <= 1'b0;
                    out_tick <= 1'b0;
                    running  <= 1'b0;
                end
            endcase
        end
    end

endmodule
